// File: rtl/ps2_tx_if.sv
// Host-side command handshake for the PS/2 transmitter: one-cycle write request
// with its byte, plus busy/done/error status returned by the transmitter.
interface ps2_tx_if;
    logic       wr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output wr, data, input busy, done, error);
    modport slave  (input wr, data, output busy, done, error);
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, shifts
// a byte with odd parity and stop bit on device clocks, then checks the ACK.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int SETUP_CYCLES   = 50,
    parameter int FILTER_CYCLES  = 8,
    parameter int START_TIMEOUT  = 375000,
    parameter int PACKET_TIMEOUT = 50000
) (
    input  logic     clock,
    input  logic     reset,
    ps2_tx_if.slave  host,
    input  logic     ps2_clk_i,
    input  logic     ps2_dat_i,
    output logic     ps2_clk_oe,
    output logic     ps2_dat_oe
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    typedef logic [18:0] cnt_t;

    localparam logic [FW-1:0] FILT_LAST   = FW'(FILTER_CYCLES - 1);
    localparam cnt_t          INHIBIT_LAST = cnt_t'(INHIBIT_CYCLES - 1);
    localparam cnt_t          SETUP_LAST   = cnt_t'(SETUP_CYCLES - 1);
    localparam cnt_t          START_LAST   = cnt_t'(START_TIMEOUT - 1);
    localparam cnt_t          PACKET_LAST  = cnt_t'(PACKET_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic          clk_p0, clk_p1, dat_p0, dat_p1;
    logic          clk_filt, dat_filt, clk_filt_q;
    logic [FW-1:0] clk_fcnt, dat_fcnt;
    logic          fall;

    state_t        state;
    cnt_t          cnt;
    logic [3:0]    bit_n;
    logic [9:0]    frame;
    logic          ack_err;
    logic          busy_r, done_r, error_r;

    // Synchronizer stages _p0/_p1, then a level filter that only follows the
    // synchronized line after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_p0     <= 1'b1;
            clk_p1     <= 1'b1;
            dat_p0     <= 1'b1;
            dat_p1     <= 1'b1;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            clk_fcnt   <= '0;
            dat_fcnt   <= '0;
        end else begin
            clk_p0     <= ps2_clk_i;
            clk_p1     <= clk_p0;
            dat_p0     <= ps2_dat_i;
            dat_p1     <= dat_p0;
            clk_filt_q <= clk_filt;

            if (clk_p1 == clk_filt) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FILT_LAST) begin
                clk_filt <= clk_p1;
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + 1'b1;
            end

            if (dat_p1 == dat_filt) begin
                dat_fcnt <= '0;
            end else if (dat_fcnt == FILT_LAST) begin
                dat_filt <= dat_p1;
                dat_fcnt <= '0;
            end else begin
                dat_fcnt <= dat_fcnt + 1'b1;
            end
        end
    end

    assign fall = clk_filt_q & ~clk_filt;

    // Byte frame is datapath only; no reset needed.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && host.wr)
            frame <= {1'b1, ~^host.data, host.data};
    end

    // Control FSM; one shared counter reloads on each state entry and on the
    // first device fall, which starts the packet timeout window.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_n      <= '0;
            ack_err    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            cnt     <= sat_inc(cnt);
            case (state)
                S_IDLE: begin
                    if (host.wr) begin
                        state      <= S_INHIBIT;
                        cnt        <= '0;
                        bit_n      <= '0;
                        busy_r     <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        state      <= S_REQ;
                        cnt        <= '0;
                        ps2_dat_oe <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (cnt == SETUP_LAST) begin
                        state      <= S_SHIFT;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (fall) begin
                        ps2_dat_oe <= ~frame[bit_n];
                        bit_n      <= bit_n + 4'd1;
                        if (bit_n == 4'd0)
                            cnt <= '0;
                        if (bit_n == 4'd9) begin
                            state <= S_ACK;
                            cnt   <= '0;
                        end
                    end else if ((bit_n == 4'd0) ? (cnt == START_LAST) : (cnt == PACKET_LAST)) begin
                        state      <= S_IDLE;
                        busy_r     <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        done_r     <= 1'b1;
                        error_r    <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        ack_err <= dat_filt;
                        state   <= S_WAIT_IDLE;
                        cnt     <= '0;
                    end else if (cnt == PACKET_LAST) begin
                        state      <= S_IDLE;
                        busy_r     <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        done_r     <= 1'b1;
                        error_r    <= 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_filt && dat_filt) begin
                        state   <= S_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        error_r <= ack_err;
                    end else if (cnt == PACKET_LAST) begin
                        state      <= S_IDLE;
                        busy_r     <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        done_r     <= 1'b1;
                        error_r    <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign host.busy  = busy_r;
    assign host.done  = done_r;
    assign host.error = error_r;
endmodule
